// File: rtl/lsu_pkg.sv
// ============================================================================
// Module : lsu_pkg
// Desc   : Shared types and helpers for the load/store unit.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } size_e;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ERR     = 3'd1,
        LD_RD   = 3'd2,
        LD_DATA = 3'd3,
        ST_WR   = 3'd4,
        RMW_RD  = 3'd5,
        RMW_WR  = 3'd6,
        RESP    = 3'd7
    } state_e;

    // Size 2'b11 is folded in here so one test covers every rejected request.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return lane[0];
            SZ_WORD: return |lane;
            default: return 1'b1;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_align.sv
// ============================================================================
// Module : lsu_align
// Desc   : Sub-word load extraction/extension and store lane merging.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [1:0]  lane_i,
    input  logic [31:0] rdata_i,
    input  logic [15:0] wdata_i,
    output logic [31:0] load_data_o,
    output logic [31:0] merge_data_o
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte       = rdata_i[{lane_i, 3'b000} +: 8];
        w_half       = rdata_i[{lane_i[1], 4'b0000} +: 16];
        load_data_o  = rdata_i;
        merge_data_o = rdata_i;
        case (size_i)
            SZ_BYTE: begin
                load_data_o = {{24{w_byte[7] & ~unsigned_i}}, w_byte};
                merge_data_o[{lane_i, 3'b000} +: 8] = wdata_i[7:0];
            end
            SZ_HALF: begin
                load_data_o = {{16{w_half[15] & ~unsigned_i}}, w_half};
                merge_data_o[{lane_i[1], 4'b0000} +: 16] = wdata_i;
            end
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/load_store_unit.sv
// ============================================================================
// Module : load_store_unit
// Desc   : Byte-addressed load/store front end for a word-addressed memory.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module load_store_unit
    import lsu_pkg::*;
#(
    parameter  int unsigned DEPTH = 1024,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          req_valid_i,
    output logic          req_ready_o,
    input  logic          req_we_i,
    input  logic [1:0]    req_size_i,
    input  logic          req_unsigned_i,
    input  logic [31:0]   req_addr_i,
    input  logic [31:0]   req_wdata_i,
    output logic          rsp_valid_o,
    output logic [31:0]   rsp_rdata_o,
    output logic          rsp_err_o,
    output logic          mem_read_en_o,
    output logic [AW-1:0] mem_read_pos_o,
    input  logic [31:0]   mem_read_data_i,
    output logic          mem_write_en_o,
    output logic [AW-1:0] mem_write_pos_o,
    output logic [31:0]   mem_write_data_o
);

    state_e          state_q;
    logic            we_q;
    logic [1:0]      size_q;
    logic            unsigned_q;
    logic [AW+1:0]   addr_q;
    logic [31:0]     wdata_q;
    logic            mem_read_en_q;
    logic            mem_write_en_q;
    logic            rsp_valid_q;
    logic [31:0]     rsp_rdata_q;
    logic            rsp_err_q;

    logic [31:0]     w_load_data;
    logic [31:0]     w_merge_data;

    // Address bits above the memory range wrap and are deliberately dropped.
    if (AW + 2 < 32) begin : g_addr_hi
        logic w_unused_addr_hi;
        assign w_unused_addr_hi = ^req_addr_i[31:AW+2];
    end

    lsu_align u_align (
        .size_i       (size_q),
        .unsigned_i   (unsigned_q),
        .lane_i       (addr_q[1:0]),
        .rdata_i      (mem_read_data_i),
        .wdata_i      (wdata_q[15:0]),
        .load_data_o  (w_load_data),
        .merge_data_o (w_merge_data)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= IDLE;
            we_q           <= 1'b0;
            size_q         <= 2'b00;
            unsigned_q     <= 1'b0;
            addr_q         <= '0;
            wdata_q        <= '0;
            mem_read_en_q  <= 1'b0;
            mem_write_en_q <= 1'b0;
            rsp_valid_q    <= 1'b0;
            rsp_rdata_q    <= '0;
            rsp_err_q      <= 1'b0;
        end else begin
            mem_read_en_q  <= 1'b0;
            mem_write_en_q <= 1'b0;
            rsp_valid_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_valid_i) begin
                        we_q       <= req_we_i;
                        size_q     <= req_size_i;
                        unsigned_q <= req_unsigned_i;
                        addr_q     <= req_addr_i[AW+1:0];
                        wdata_q    <= req_wdata_i;
                        if (is_misaligned(req_size_i, req_addr_i[1:0])) begin
                            state_q <= ERR;
                        end else if (!req_we_i) begin
                            state_q       <= LD_RD;
                            mem_read_en_q <= 1'b1;
                        end else if (req_size_i == SZ_WORD) begin
                            state_q        <= ST_WR;
                            mem_write_en_q <= 1'b1;
                        end else begin
                            state_q       <= RMW_RD;
                            mem_read_en_q <= 1'b1;
                        end
                    end
                end
                ERR: begin
                    state_q     <= RESP;
                    rsp_valid_q <= 1'b1;
                    rsp_rdata_q <= '0;
                    rsp_err_q   <= 1'b1;
                end
                LD_RD: begin
                    state_q <= LD_DATA;
                end
                LD_DATA: begin
                    state_q     <= RESP;
                    rsp_valid_q <= 1'b1;
                    rsp_rdata_q <= w_load_data;
                    rsp_err_q   <= 1'b0;
                end
                RMW_RD: begin
                    state_q        <= RMW_WR;
                    mem_write_en_q <= 1'b1;
                end
                ST_WR, RMW_WR: begin
                    state_q     <= RESP;
                    rsp_valid_q <= 1'b1;
                    rsp_rdata_q <= '0;
                    rsp_err_q   <= 1'b0;
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign req_ready_o     = (state_q == IDLE);
    assign rsp_valid_o     = rsp_valid_q;
    assign rsp_rdata_o     = rsp_rdata_q;
    assign rsp_err_o       = rsp_err_q;
    assign mem_read_en_o   = mem_read_en_q;
    assign mem_write_en_o  = mem_write_en_q;
    assign mem_read_pos_o  = addr_q[AW+1:2];
    assign mem_write_pos_o = addr_q[AW+1:2];

    // The merge is taken straight off the read data so the RMW write lands one
    // cycle after the read instead of two.
    assign mem_write_data_o = !we_q ? '0 :
                              (state_q == RMW_WR) ? w_merge_data : wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// ============================================================================
// Module : tb_load_store_unit
// Desc   : Directed + random bench for load_store_unit against a byte-level model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_load_store_unit;

    localparam int DEPTH = 1024;
    localparam int AW    = 10;

    logic          clk = 1'b0;
    logic          rst_ni;
    logic          req_valid;
    logic          req_ready_o;
    logic          req_we;
    logic [1:0]    req_size;
    logic          req_unsigned;
    logic [31:0]   req_addr;
    logic [31:0]   req_wdata;
    logic          rsp_valid_o;
    logic [31:0]   rsp_rdata_o;
    logic          rsp_err_o;
    logic          mem_read_en_o;
    logic [AW-1:0] mem_read_pos_o;
    logic [31:0]   mem_read_data;
    logic          mem_write_en_o;
    logic [AW-1:0] mem_write_pos_o;
    logic [31:0]   mem_write_data_o;

    logic          mem_clear;
    logic [31:0]   mem     [DEPTH];
    logic [31:0]   ref_mem [DEPTH];

    int total = 0;
    int bad   = 0;
    int nreq  = 0;

    always #5 clk = ~clk;

    load_store_unit #(.DEPTH(DEPTH)) dut (
        .clk_i            (clk),
        .rst_ni           (rst_ni),
        .req_valid_i      (req_valid),
        .req_ready_o      (req_ready_o),
        .req_we_i         (req_we),
        .req_size_i       (req_size),
        .req_unsigned_i   (req_unsigned),
        .req_addr_i       (req_addr),
        .req_wdata_i      (req_wdata),
        .rsp_valid_o      (rsp_valid_o),
        .rsp_rdata_o      (rsp_rdata_o),
        .rsp_err_o        (rsp_err_o),
        .mem_read_en_o    (mem_read_en_o),
        .mem_read_pos_o   (mem_read_pos_o),
        .mem_read_data_i  (mem_read_data),
        .mem_write_en_o   (mem_write_en_o),
        .mem_write_pos_o  (mem_write_pos_o),
        .mem_write_data_o (mem_write_data_o)
    );

    // Attached memory: registered read, no byte enables.
    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= 32'h0000_0001;
        end else begin
            if (mem_read_en_o)  mem_read_data <= mem[mem_read_pos_o];
            if (mem_write_en_o) mem[mem_write_pos_o] <= mem_write_data_o;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [1:0] sz,
                                             input logic uns, input logic [1:0] lane);
        int          sh;
        logic [31:0] v;
        sh = 8 * int'(lane);
        v  = word >> sh;
        if (sz == 2'd0) begin
            v = v & 32'h0000_00FF;
            if (!uns && v[7]) v = v | 32'hFFFF_FF00;
        end else if (sz == 2'd1) begin
            v = v & 32'h0000_FFFF;
            if (!uns && v[15]) v = v | 32'hFFFF_0000;
        end else begin
            v = word;
        end
        return v;
    endfunction

    function automatic logic [31:0] ref_store(input logic [31:0] word, input logic [1:0] sz,
                                              input logic [1:0] lane, input logic [31:0] wd);
        int          sh;
        logic [31:0] mask;
        if (sz == 2'd2) return wd;
        sh   = 8 * int'(lane);
        mask = (sz == 2'd0) ? 32'h0000_00FF : 32'h0000_FFFF;
        mask = mask << sh;
        return (word & ~mask) | ((wd << sh) & mask);
    endfunction

    task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd);
        int          idx, e_lat, e_rd_at, e_wr_at;
        logic        e_err;
        logic [31:0] e_rdata, e_wdata;
        int          rsp_at, rd_n, wr_n, rd_at, wr_at;
        logic [31:0] rd_pos, wr_pos, wr_data, o_rdata;
        logic        o_err;
        string       p;

        nreq++;
        p     = $sformatf("r%0d", nreq);
        idx   = int'((addr >> 2) % DEPTH);
        e_err = (sz == 2'd3) || (sz == 2'd1 && addr[0]) || (sz == 2'd2 && addr[1:0] != 2'd0);
        e_rdata = 32'h0; e_wdata = 32'h0; e_rd_at = 0; e_wr_at = 0;
        if (e_err) begin
            e_lat = 2;
        end else if (!we) begin
            e_lat = 3; e_rd_at = 1;
            e_rdata = ref_load(ref_mem[idx], sz, uns, addr[1:0]);
        end else if (sz == 2'd2) begin
            e_lat = 2; e_wr_at = 1;
            e_wdata = wd; ref_mem[idx] = wd;
        end else begin
            e_lat = 3; e_rd_at = 1; e_wr_at = 2;
            e_wdata = ref_store(ref_mem[idx], sz, addr[1:0], wd);
            ref_mem[idx] = e_wdata;
        end

        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = addr; req_wdata = wd;
        check({p, "_ready"}, 32'(req_ready_o), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;

        rsp_at = 0; rd_n = 0; wr_n = 0; rd_at = 0; wr_at = 0;
        rd_pos = 0; wr_pos = 0; wr_data = 0; o_rdata = 0; o_err = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            if (mem_read_en_o)  begin rd_n++; rd_at = k; rd_pos = 32'(mem_read_pos_o); end
            if (mem_write_en_o) begin
                wr_n++; wr_at = k; wr_pos = 32'(mem_write_pos_o); wr_data = mem_write_data_o;
            end
            if (rsp_valid_o) begin
                rsp_at = k; o_rdata = rsp_rdata_o; o_err = rsp_err_o;
                break;
            end
            @(negedge clk);
        end

        check({p, "_latency"}, rsp_at, e_lat);
        check({p, "_nread"}, rd_n, (e_rd_at != 0) ? 1 : 0);
        check({p, "_nwrite"}, wr_n, (e_wr_at != 0) ? 1 : 0);
        if (e_rd_at != 0) begin
            check({p, "_rd_at"}, rd_at, e_rd_at);
            check({p, "_rd_pos"}, rd_pos, idx);
        end
        if (e_wr_at != 0) begin
            check({p, "_wr_at"}, wr_at, e_wr_at);
            check({p, "_wr_pos"}, wr_pos, idx);
            check({p, "_wr_data"}, wr_data, e_wdata);
        end
        check({p, "_rdata"}, o_rdata, e_rdata);
        check({p, "_err"}, 32'(o_err), 32'(e_err));

        @(negedge clk);
        check({p, "_pulse"}, 32'(rsp_valid_o), 32'd0);
        check({p, "_hold"}, rsp_rdata_o, o_rdata);
    endtask

    initial begin
        int wr_seen, rsp_seen, nmis;

        rst_ni = 1'b0; mem_clear = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0000_0001;
        #1;
        check("rst_ready", 32'(req_ready_o), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        check("rst_rdata", rsp_rdata_o, 32'd0);
        check("rst_err", 32'(rsp_err_o), 32'd0);
        check("rst_rd_en", 32'(mem_read_en_o), 32'd0);
        check("rst_wr_en", 32'(mem_write_en_o), 32'd0);
        check("rst_rd_pos", 32'(mem_read_pos_o), 32'd0);
        check("rst_wr_pos", 32'(mem_write_pos_o), 32'd0);
        check("rst_wr_data", mem_write_data_o, 32'd0);
        repeat (2) @(negedge clk);
        mem_clear = 1'b0; rst_ni = 1'b1;

        // Load of the cleared memory, sign/zero extension and RMW merging
        do_req(1'b0, 2'd2, 1'b0, 32'h0000_0008, 32'h0);
        do_req(1'b1, 2'd2, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF);
        do_req(1'b0, 2'd0, 1'b0, 32'h0000_0013, 32'h0);
        do_req(1'b0, 2'd0, 1'b1, 32'h0000_0013, 32'h0);
        do_req(1'b0, 2'd1, 1'b0, 32'h0000_0012, 32'h0);
        do_req(1'b1, 2'd0, 1'b0, 32'h0000_0011, 32'h5555_55AB);
        do_req(1'b1, 2'd1, 1'b0, 32'h0000_0012, 32'hFFFF_1234);
        do_req(1'b0, 2'd2, 1'b0, 32'h0000_0010, 32'h0);
        do_req(1'b0, 2'd1, 1'b1, 32'h0000_0012, 32'h0);
        // Misaligned and illegal-size requests
        do_req(1'b0, 2'd1, 1'b0, 32'h0000_0003, 32'h0);
        do_req(1'b1, 2'd2, 1'b0, 32'h0000_0006, 32'h1111_2222);
        do_req(1'b0, 2'd3, 1'b0, 32'h0000_0020, 32'h0);
        do_req(1'b1, 2'd3, 1'b0, 32'h0000_0020, 32'h3333_4444);
        // Address wrap
        do_req(1'b1, 2'd2, 1'b0, 32'h0000_1000, 32'hCAFE_F00D);
        do_req(1'b0, 2'd2, 1'b0, 32'h0000_0000, 32'h0);
        do_req(1'b0, 2'd0, 1'b0, 32'hFFFF_F003, 32'h0);

        // Reset while a byte store sits in its read phase
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = 32'h0000_0024; req_wdata = 32'h0000_00AB;
        @(negedge clk);
        req_valid = 1'b0;
        check("rstmid_rmw_rd", 32'(mem_read_en_o), 32'd1);
        rst_ni = 1'b0;
        #1;
        check("rstmid_ready", 32'(req_ready_o), 32'd1);
        check("rstmid_rd_en", 32'(mem_read_en_o), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_ni = 1'b1;
        wr_seen = 0; rsp_seen = 0;
        for (int k = 0; k < 5; k++) begin
            if (mem_write_en_o) wr_seen++;
            if (rsp_valid_o)    rsp_seen++;
            @(negedge clk);
        end
        check("rstmid_no_write", wr_seen, 0);
        check("rstmid_no_rsp", rsp_seen, 0);
        check("rstmid_ready_after", 32'(req_ready_o), 32'd1);

        // Random traffic concentrated on a few words and their wrapped aliases
        for (int i = 0; i < 80; i++) begin
            logic [31:0] a;
            logic [1:0]  sz;
            sz = 2'($urandom_range(0, 3));
            a  = ((32'($urandom_range(0, 15)) + DEPTH * 32'($urandom_range(0, 3))) << 2)
                 | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'd3) sz = 2'($urandom_range(0, 2));
                if (sz == 2'd1) a[0] = 1'b0;
                if (sz == 2'd2) a[1:0] = 2'b00;
            end
            do_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom());
        end

        nmis = 0;
        for (int i = 0; i < DEPTH; i++) if (mem[i] !== ref_mem[i]) nmis++;
        check("mem_image", nmis, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits directly upstream of the core's word-addressed data memory.
- Converts byte-addressed byte/half/word load and store requests from the execute stage into whole-word memory accesses.
- Sub-word stores are done as read-modify-write because the memory has no byte enables.
- One request in flight at a time: valid/ready handshake on the request side, single-cycle response pulse to writeback.

Parameters:
- DEPTH, 1024, number of 32-bit words in the attached memory; must be a power of two and at least 2.
- AW, $clog2(DEPTH), memory word-index width (derived, not overridden).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request accepted when valid && ready
- req_we_i  in  1  1 = store, 0 = load
- req_size_i  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned_i  in  1  zero-extend a sub-word load
- req_addr_i  in  32  byte address
- req_wdata_i  in  32  store data, right-aligned
- rsp_valid_o  out  1  one-cycle response pulse
- rsp_rdata_o  out  32  load result; 0 for stores and errors
- rsp_err_o  out  1  misaligned or illegal size
- mem_read_en_o  out  1  memory read enable
- mem_read_pos_o  out  AW  memory read word index
- mem_read_data_i  in  32  memory read data, valid the cycle after mem_read_en_o
- mem_write_en_o  out  1  memory write enable
- mem_write_pos_o  out  AW  memory write word index
- mem_write_data_o  out  32  memory write data

Behaviour:
- Reset: rst_ni is asynchronous, active-low; clock is clk_i. Reset forces state IDLE and clears all captured registers. Output values under reset:
  - rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0
  - mem_read_en_o=0, mem_write_en_o=0
  - all mem_*_pos_o and mem_write_data_o = 0
  - req_ready_o=1
- Reset mid-operation abandons the request. No memory write and no response occur after deassertion.
- req_ready_o = (state == IDLE). On accept (cycle T), capture we, size, unsigned, addr and wdata.
- Word index = addr[AW+1:2]; bits above AW+1 are ignored, so addresses wrap modulo 4*DEPTH. Lane = addr[1:0].
- Error check at accept: size==11, half with addr[0]=1, or word with addr[1:0]!=0.
- Memory-side outputs are driven only from state and captured registers, never combinationally from req_*_i.
- States:
  - IDLE: on accept go to ERR if the error check fails; else go to LD_RD (load), ST_WR (word store) or RMW_RD (byte/half store).
  - ERR: no memory access; go to RESP with err=1, rdata=0.
  - LD_RD: mem_read_en_o=1; go to LD_DATA.
  - LD_DATA: extract from mem_read_data_i.
    - Byte: lane k gives bits [8k+7:8k].
    - Half: addr[1]=h gives bits [16h+15:16h].
    - Sign-extend unless unsigned; word ignores unsigned.
    - Register the result, go to RESP.
  - ST_WR: mem_write_en_o=1, write data = captured wdata; go to RESP with rdata=0.
  - RMW_RD: mem_read_en_o=1; go to RMW_WR.
  - RMW_WR: mem_write_en_o=1, write data = mem_read_data_i with the target lane(s) replaced by wdata[7:0] or wdata[15:0]; go to RESP.
  - RESP: rsp_valid_o=1 for exactly one cycle with the registered rdata and err; go to IDLE.
- Latency from accept at T to rsp_valid_o:
  - load: T+3
  - word store: T+2
  - sub-word store: T+3
  - error: T+2
- A new request can be accepted the cycle after RESP.
- There is never more than one memory access outstanding, so the memory's same-address read/write bypass never occurs.
- rsp_rdata_o and rsp_err_o hold their last value while rsp_valid_o=0.

Decomposition:
- lsu_pkg holds:
  - size enum (SZ_BYTE, SZ_HALF, SZ_WORD)
  - state enum (IDLE, ERR, LD_RD, LD_DATA, ST_WR, RMW_RD, RMW_WR, RESP)
  - a misalignment check function
- Sub-module lsu_align (combinational) does load extraction/extension and store lane merging, so both are unit-testable in isolation.

Test Plan:
- Reset the memory (every word = 0x00000001), then word load addr 0x8 -> rsp_valid at T+3, rdata 0x00000001, err 0; mem_read_en_o pulses at T+1, index 2.
- Word store 0xDEADBEEF to 0x10, then byte loads at 0x13: signed -> 0xFFFFFFDE, unsigned -> 0x000000DE; half load at 0x12 signed -> 0xFFFFDEAD.
- Byte store 0xAB to 0x11 over 0xDEADBEEF -> memory word 4 = 0xDEADABEF; half store 0x1234 to 0x12 -> 0x1234ABEF; write occurs at T+2, response at T+3.
- Half load at 0x3 and word store at 0x6 -> rsp_err 1, rdata 0 at T+2; no mem_read_en/mem_write_en pulse; memory contents unchanged.
- Address wrap with DEPTH=1024: word store to 0x1000 lands in word 0; size 11 -> err.
- Assert rst_ni low during RMW_RD of a byte store -> no write to memory; after release req_ready_o=1 and rsp_valid_o stays 0.
